// File: rtl/anim_pkg.sv
// Shared types and default widths for the table-driven sprite animation sequencer.
package anim_pkg;

  localparam int unsigned ANIM_COORD_W = 11;
  localparam int unsigned ANIM_HOLD_W  = 5;

  typedef enum logic [1:0] {
    ANIM_LOOP      = 2'd0,
    ANIM_HOLD_LAST = 2'd1,
    ANIM_ONESHOT   = 2'd2
  } anim_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HELD = 2'd2
  } anim_seq_state_t;

endpackage

// File: rtl/anim_frame_table.sv
// Frame table: per-entry sheet row/column and hold count; synchronous write and clear,
// combinational read.
module anim_frame_table
  import anim_pkg::*;
#(
  parameter int unsigned  MAX_FRAMES = 8,
  parameter int unsigned  COORD_W    = ANIM_COORD_W,
  parameter int unsigned  HOLD_W     = ANIM_HOLD_W,
  localparam int unsigned IDX_W      = $clog2(MAX_FRAMES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [IDX_W:0]     wr_idx,
  input  logic [COORD_W-1:0] wr_row,
  input  logic [COORD_W-1:0] wr_col,
  input  logic [HOLD_W-1:0]  wr_hold,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [COORD_W-1:0] rd_row,
  output logic [COORD_W-1:0] rd_col,
  output logic [HOLD_W-1:0]  rd_hold
);

  localparam logic [IDX_W:0] DEPTH = (IDX_W+1)'(MAX_FRAMES);

  logic [COORD_W-1:0] row_q  [MAX_FRAMES];
  logic [COORD_W-1:0] row_d  [MAX_FRAMES];
  logic [COORD_W-1:0] col_q  [MAX_FRAMES];
  logic [COORD_W-1:0] col_d  [MAX_FRAMES];
  logic [HOLD_W-1:0]  hold_q [MAX_FRAMES];
  logic [HOLD_W-1:0]  hold_d [MAX_FRAMES];

  // Out-of-range indices are dropped rather than aliased onto a low entry.
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    hold_d = hold_q;
    if (wr_en && (wr_idx < DEPTH)) begin
      row_d[wr_idx[IDX_W-1:0]]  = wr_row;
      col_d[wr_idx[IDX_W-1:0]]  = wr_col;
      hold_d[wr_idx[IDX_W-1:0]] = wr_hold;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < MAX_FRAMES; i++) begin
        row_q[i]  <= '0;
        col_q[i]  <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      hold_q <= hold_d;
    end
  end

  always_comb begin
    rd_row  = row_q[rd_idx];
    rd_col  = col_q[rd_idx];
    rd_hold = hold_q[rd_idx];
  end

endmodule

// File: rtl/anim_seq_fsm.sv
// Sprite animation sequencer: steps through the frame table on anim_tick with per-frame
// holds and loop / hold-last / one-shot end behaviour.
module anim_seq_fsm
  import anim_pkg::*;
#(
  parameter int unsigned  MAX_FRAMES = 8,
  parameter int unsigned  COORD_W    = ANIM_COORD_W,
  parameter int unsigned  HOLD_W     = ANIM_HOLD_W,
  localparam int unsigned IDX_W      = $clog2(MAX_FRAMES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               anim_tick,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [IDX_W:0]     num_frames,
  input  logic               wr_en,
  input  logic [IDX_W:0]     wr_idx,
  input  logic [COORD_W-1:0] wr_row,
  input  logic [COORD_W-1:0] wr_col,
  input  logic [HOLD_W-1:0]  wr_hold,
  output logic [COORD_W-1:0] anim_row,
  output logic [COORD_W-1:0] anim_col,
  output logic [IDX_W-1:0]   frame_idx,
  output logic               busy,
  output logic               done
);

  localparam logic [IDX_W:0] MAX_LEN = (IDX_W+1)'(MAX_FRAMES);
  localparam logic [IDX_W:0] ONE_LEN = (IDX_W+1)'(1);

  anim_seq_state_t   state_q, state_d;
  logic [IDX_W-1:0]  frame_idx_q, frame_idx_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic [IDX_W:0]    len_q, len_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [HOLD_W-1:0] cur_hold;

  anim_frame_table #(
    .MAX_FRAMES (MAX_FRAMES),
    .COORD_W    (COORD_W),
    .HOLD_W     (HOLD_W)
  ) u_table (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_hold (wr_hold),
    .rd_idx  (frame_idx_q),
    .rd_row  (anim_row),
    .rd_col  (anim_col),
    .rd_hold (cur_hold)
  );

  always_comb begin
    state_d     = state_q;
    frame_idx_d = frame_idx_q;
    hold_cnt_d  = hold_cnt_q;
    mode_d      = mode_q;
    len_d       = len_q;
    done_d      = 1'b0;

    if (start) begin
      mode_d      = mode;
      frame_idx_d = '0;
      hold_cnt_d  = '0;
      state_d     = PLAY;
      if (num_frames == '0)          len_d = ONE_LEN;
      else if (num_frames > MAX_LEN) len_d = MAX_LEN;
      else                           len_d = num_frames;
    end else if ((state_q == PLAY) && anim_tick) begin
      // Hold bound comes from the live entry, so a rewrite below hold_cnt advances at once.
      if (hold_cnt_q < cur_hold) begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end else begin
        hold_cnt_d = '0;
        if ({1'b0, frame_idx_q} < (len_q - ONE_LEN)) begin
          frame_idx_d = frame_idx_q + IDX_W'(1);
        end else begin
          case (mode_q)
            ANIM_LOOP: frame_idx_d = '0;
            ANIM_ONESHOT: begin
              frame_idx_d = '0;
              state_d     = IDLE;
              done_d      = 1'b1;
            end
            default: begin
              state_d = HELD;
              done_d  = 1'b1;
            end
          endcase
        end
      end
    end

    busy_d = (state_d == PLAY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      frame_idx_q <= '0;
      hold_cnt_q  <= '0;
      mode_q      <= ANIM_LOOP;
      len_q       <= ONE_LEN;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_idx_q <= frame_idx_d;
      hold_cnt_q  <= hold_cnt_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign frame_idx = frame_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_anim_seq_fsm.sv
// Directed self-checking bench for anim_seq_fsm with hand-computed expectations.
module tb_anim_seq_fsm;

  localparam int unsigned MAX_FRAMES = 8;
  localparam int unsigned COORD_W    = 11;
  localparam int unsigned HOLD_W     = 5;
  localparam int unsigned IDX_W      = 3;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               anim_tick = 1'b0;
  logic               start = 1'b0;
  logic [1:0]         mode = 2'd0;
  logic [IDX_W:0]     num_frames = '0;
  logic               wr_en = 1'b0;
  logic [IDX_W:0]     wr_idx = '0;
  logic [COORD_W-1:0] wr_row = '0;
  logic [COORD_W-1:0] wr_col = '0;
  logic [HOLD_W-1:0]  wr_hold = '0;
  logic [COORD_W-1:0] anim_row;
  logic [COORD_W-1:0] anim_col;
  logic [IDX_W-1:0]   frame_idx;
  logic               busy;
  logic               done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  anim_seq_fsm #(
    .MAX_FRAMES (MAX_FRAMES),
    .COORD_W    (COORD_W),
    .HOLD_W     (HOLD_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .anim_tick  (anim_tick),
    .start      (start),
    .mode       (mode),
    .num_frames (num_frames),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_hold    (wr_hold),
    .anim_row   (anim_row),
    .anim_col   (anim_col),
    .frame_idx  (frame_idx),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input int row, input int col, input int hold);
    wr_en   = 1'b1;
    wr_idx  = (IDX_W+1)'(idx);
    wr_row  = COORD_W'(row);
    wr_col  = COORD_W'(col);
    wr_hold = HOLD_W'(hold);
    step();
    wr_en   = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] m, input int n);
    start      = 1'b1;
    mode       = m;
    num_frames = (IDX_W+1)'(n);
    step();
    start      = 1'b0;
  endtask

  task automatic tick();
    anim_tick = 1'b1;
    step();
    anim_tick = 1'b0;
  endtask

  int loop_exp [14] = '{0, 1, 2, 2, 2, 0, 0, 1, 2, 2, 2, 0, 0, 1};

  initial begin
    step();
    step();
    reset = 1'b0;
    step();
    chk("rst_row", anim_row, 0);
    chk("rst_col", anim_col, 0);
    chk("rst_idx", frame_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // Three-frame hold-last; the last frame shows for one tick before expiring.
    wr(0, 90, 23, 0);
    wr(1, 120, 0, 0);
    wr(2, 120, 23, 0);
    do_start(2'd1, 3);
    chk("hl_row0", anim_row, 90);
    chk("hl_col0", anim_col, 23);
    chk("hl_busy0", busy, 1);
    tick();
    chk("hl_row1", anim_row, 120);
    chk("hl_col1", anim_col, 0);
    tick();
    chk("hl_row2", anim_row, 120);
    chk("hl_col2", anim_col, 23);
    chk("hl_done2", done, 0);
    tick();
    chk("hl_done3", done, 1);
    chk("hl_busy3", busy, 0);
    chk("hl_idx3", frame_idx, 2);
    tick();
    chk("hl_done4", done, 0);
    tick();
    chk("hl_row5", anim_row, 120);
    chk("hl_col5", anim_col, 23);
    chk("hl_busy5", busy, 0);

    // Looping with holds 1,0,2.
    wr(0, 10, 11, 1);
    wr(1, 20, 21, 0);
    wr(2, 30, 31, 2);
    do_start(2'd0, 3);
    chk("lp_idx0", frame_idx, 0);
    for (int i = 0; i < 14; i++) begin
      tick();
      chk($sformatf("lp_idx_t%0d", i + 1), frame_idx, loop_exp[i]);
      chk($sformatf("lp_done_t%0d", i + 1), done, 0);
      chk($sformatf("lp_busy_t%0d", i + 1), busy, 1);
    end

    // One-shot, length 2.
    wr(0, 1, 1, 0);
    wr(1, 2, 2, 0);
    do_start(2'd2, 2);
    tick();
    chk("os_idx1", frame_idx, 1);
    chk("os_done1", done, 0);
    tick();
    chk("os_idx2", frame_idx, 0);
    chk("os_busy2", busy, 0);
    chk("os_done2", done, 1);
    tick();
    chk("os_idx3", frame_idx, 0);
    chk("os_done3", done, 0);

    // Restart colliding with a tick at frame 2, hold_cnt 1.
    wr(0, 1, 1, 1);
    do_start(2'd0, 3);
    tick();
    tick();
    tick();
    tick();
    chk("rs_pre_idx", frame_idx, 2);
    start      = 1'b1;
    anim_tick  = 1'b1;
    mode       = 2'd0;
    num_frames = 4'd3;
    step();
    start      = 1'b0;
    anim_tick  = 1'b0;
    chk("rs_idx", frame_idx, 0);
    chk("rs_busy", busy, 1);
    tick();
    chk("rs_hold_idx", frame_idx, 0);
    tick();
    chk("rs_adv_idx", frame_idx, 1);

    // num_frames=0 clamps to one frame.
    wr(0, 1, 1, 0);
    do_start(2'd2, 0);
    tick();
    chk("c0_idx", frame_idx, 0);
    chk("c0_done", done, 1);
    chk("c0_busy", busy, 0);

    // num_frames=15 clamps to eight frames.
    for (int i = 0; i < 8; i++) wr(i, 100 + i, i, 0);
    do_start(2'd1, 15);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("c15_idx_t%0d", i), frame_idx, i);
      chk($sformatf("c15_done_t%0d", i), done, 0);
    end
    chk("c15_row7", anim_row, 107);
    tick();
    chk("c15_done8", done, 1);
    chk("c15_idx8", frame_idx, 7);

    // Out-of-range write must not alias onto entry 0.
    do_start(2'd1, 1);
    chk("wr_row0", anim_row, 100);
    wr(8, 999, 999, 31);
    chk("wr8_row", anim_row, 100);
    chk("wr8_col", anim_col, 0);

    // Live rewrite of the displayed frame.
    wr(0, 555, 0, 0);
    chk("live_row", anim_row, 555);
    chk("live_busy", busy, 1);

    // Reset mid-play clears state and table.
    wr(1, 77, 0, 3);
    tick();
    chk("pre_rst_idx", frame_idx, 0);
    chk("pre_rst_done", done, 1);
    do_start(2'd0, 2);
    tick();
    chk("pre_rst_idx1", frame_idx, 1);
    chk("pre_rst_row1", anim_row, 77);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_row", anim_row, 0);
    chk("mr_col", anim_col, 0);
    chk("mr_idx", frame_idx, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    do_start(2'd0, 2);
    chk("mr_tbl_row0", anim_row, 0);
    tick();
    chk("mr_tbl_row1", anim_row, 0);
    chk("mr_tbl_idx1", frame_idx, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
